cray_mem_ioc: RTL

//  Parametrised memory + I/O controller between cray_top's memory port and system RAM / N uart64 channels.

---
 rtl/cray_mem_ioc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cray_mem_ioc.sv
// Memory + I/O controller: pipelined RAM reads, decoded per-channel UART MMIO window,
// TX holding registers with stall backpressure and a sticky unmapped-access error flag.
module cray_mem_ioc #(
  parameter int                DATA_W        = 64,
  parameter int                ADDR_W        = 22,
  parameter int                LOG_MEM_DEPTH = 12,
  parameter int                RD_LAT        = 2,
  parameter int                NUM_UART      = 2,
  parameter logic [ADDR_W-1:0] IO_BASE       = 22'h080000,
  parameter string             INIT_FILE     = "cray_rom.txt"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            i_mem_addr,
  input  logic [DATA_W-1:0]            i_mem_wr_data,
  input  logic                         i_mem_wr_en,
  input  logic                         i_mem_ce,
  output logic                         o_mem_stall,
  output logic [DATA_W-1:0]            o_mem_rd_data,
  output logic                         o_mem_vld,
  output logic [NUM_UART-1:0]          o_tx_start,
  output logic [NUM_UART*DATA_W-1:0]   o_tx_data,
  input  logic [NUM_UART-1:0]          i_tx_busy,
  output logic [NUM_UART-1:0]          o_rx_clr,
  input  logic [NUM_UART*DATA_W-1:0]   i_rx_data,
  input  logic [NUM_UART-1:0]          i_rx_rdy
);

  localparam int                MEM_DEPTH   = 1 << LOG_MEM_DEPTH;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = IO_BASE + ADDR_W'('h100);
  localparam logic [ADDR_W-1:0] IO_SPAN     = ADDR_W'(4 * NUM_UART);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT, TX_BUSY} tx_state_t;

  logic [ADDR_W-1:0]   io_off;
  logic [2:0]          chan_idx;
  logic [1:0]          reg_sel;
  logic                chan_hit, status_hit, ram_hit, unmapped;
  logic [NUM_UART-1:0] sel_chan, hold_full, tx_busy_stat;
  logic                accept, wr_acc, rd_acc;
  logic                err_reg;
  logic [DATA_W-1:0]   io_rd_data;

  // Address decode; the MMIO window takes priority so it never aliases into RAM.
  assign io_off     = i_mem_addr - IO_BASE;
  assign chan_idx   = io_off[4:2];
  assign reg_sel    = io_off[1:0];
  assign chan_hit   = (i_mem_addr >= IO_BASE) && (io_off < IO_SPAN);
  assign status_hit = (i_mem_addr == STATUS_ADDR);
  assign ram_hit    = (i_mem_addr[ADDR_W-1:LOG_MEM_DEPTH] == '0) && !chan_hit && !status_hit;
  assign unmapped   = !ram_hit && !chan_hit && !status_hit;

  for (genvar gi = 0; gi < NUM_UART; gi++) begin : g_sel
    assign sel_chan[gi] = chan_hit && (chan_idx == 3'(gi));
  end

  assign o_mem_stall = i_mem_ce && i_mem_wr_en && chan_hit && (reg_sel == 2'd3) &&
                       |(sel_chan & hold_full);
  assign accept      = i_mem_ce && !o_mem_stall;
  assign wr_acc      = accept && i_mem_wr_en;
  assign rd_acc      = accept && !i_mem_wr_en;

  always_comb begin
    io_rd_data = '0;
    if (status_hit) begin
      io_rd_data[0] = err_reg;
      for (int c = 0; c < NUM_UART; c++) io_rd_data[8+c] = hold_full[c];
    end
    for (int c = 0; c < NUM_UART; c++) begin
      if (sel_chan[c]) begin
        case (reg_sel)
          2'd0:    io_rd_data[0] = tx_busy_stat[c];
          2'd1:    io_rd_data[0] = i_rx_rdy[c];
          2'd2:    io_rd_data    = i_rx_data[c*DATA_W +: DATA_W];
          default: io_rd_data    = '0;
        endcase
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (accept && unmapped) begin
      err_reg <= 1'b1;
    end else if (wr_acc && status_hit) begin
      err_reg <= 1'b0;
    end
  end

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (wr_acc && ram_hit) mem[i_mem_addr[LOG_MEM_DEPTH-1:0]] <= i_mem_wr_data;
    if (rd_acc) ram_q <= mem[i_mem_addr[LOG_MEM_DEPTH-1:0]];
  end

  logic              s1_vld_reg, s1_is_ram_reg;
  logic [DATA_W-1:0] s1_io_reg, s1_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_reg    <= 1'b0;
      s1_is_ram_reg <= 1'b0;
      s1_io_reg     <= '0;
    end else begin
      s1_vld_reg <= rd_acc;
      if (rd_acc) begin
        s1_is_ram_reg <= ram_hit;
        s1_io_reg     <= io_rd_data;
      end
    end
  end

  assign s1_data = s1_is_ram_reg ? ram_q : s1_io_reg;

  if (RD_LAT == 1) begin : g_lat1
    assign o_mem_vld     = s1_vld_reg;
    assign o_mem_rd_data = s1_data;
  end else begin : g_latn
    logic [RD_LAT-2:0] vld_pipe;
    logic [DATA_W-1:0] data_pipe [RD_LAT-1];

    always_ff @(posedge clk) begin
      if (!rst) begin
        vld_pipe <= '0;
        for (int i = 0; i < RD_LAT - 1; i++) data_pipe[i] <= '0;
      end else begin
        vld_pipe[0]  <= s1_vld_reg;
        data_pipe[0] <= s1_data;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          vld_pipe[i]  <= vld_pipe[i-1];
          data_pipe[i] <= data_pipe[i-1];
        end
      end
    end

    assign o_mem_vld     = vld_pipe[RD_LAT-2];
    assign o_mem_rd_data = data_pipe[RD_LAT-2];
  end

  for (genvar gi = 0; gi < NUM_UART; gi++) begin : g_chan
    tx_state_t         state_reg, state_next;
    logic              wait_cnt_reg, wait_cnt_next;
    logic              hold_full_reg, rx_clr_reg, tx_start;
    logic [DATA_W-1:0] hold_data_reg;
    logic              load, rx_hit;

    assign load   = wr_acc && sel_chan[gi] && (reg_sel == 2'd3);
    assign rx_hit = wr_acc && sel_chan[gi] && (reg_sel == 2'd2) && i_rx_rdy[gi];

    always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      tx_start      = 1'b0;
      case (state_reg)
        TX_IDLE:  if (hold_full_reg && !i_tx_busy[gi]) state_next = TX_START;
        TX_START: begin
          tx_start      = 1'b1;
          wait_cnt_next = 1'b0;
          state_next    = TX_WAIT;
        end
        // Give the UART two cycles to raise busy before assuming it was missed.
        TX_WAIT: begin
          if (i_tx_busy[gi])     state_next = TX_BUSY;
          else if (wait_cnt_reg) state_next = TX_IDLE;
          else                   wait_cnt_next = 1'b1;
        end
        TX_BUSY:  if (!i_tx_busy[gi]) state_next = TX_IDLE;
        default:  state_next = TX_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        state_reg     <= TX_IDLE;
        wait_cnt_reg  <= 1'b0;
        hold_full_reg <= 1'b0;
        hold_data_reg <= '0;
        rx_clr_reg    <= 1'b0;
      end else begin
        state_reg    <= state_next;
        wait_cnt_reg <= wait_cnt_next;
        rx_clr_reg   <= rx_hit;
        if (load) begin
          hold_full_reg <= 1'b1;
          hold_data_reg <= i_mem_wr_data;
        end else if (tx_start) begin
          hold_full_reg <= 1'b0;
        end
      end
    end

    assign hold_full[gi]                     = hold_full_reg;
    assign tx_busy_stat[gi]                  = (state_reg != TX_IDLE) || hold_full_reg || i_tx_busy[gi];
    assign o_tx_start[gi]                    = tx_start;
    assign o_tx_data[gi*DATA_W +: DATA_W]    = hold_data_reg;
    assign o_rx_clr[gi]                      = rx_clr_reg;
  end

endmodule
